moving_average_pipelined: RTL
=============================

Name: moving_average_pipelined

Overview:
- Streaming boxcar mean estimator for 32-bit signed samples. Each output is the average of the last M accepted samples.
- It is the low-pass complement of the mean-removal stage: it supplies the DC/mean track that the mean-removal stage subtracts.
- It sits in the same sample stream, between the ADC/acquisition front end and downstream processing or logging.
- Pipelined circular-buffer implementation with a running accumulator and a zero-fill clear sequence.

Parameters:
- M, 32: window length in samples. Must be a power of two, and M >= 4.
- LOG2M, 5: log2(M). Used for the divide shift and for the index width.

Ports:
- clock  input  1  system clock. All state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- restart  input  1  synchronous pulse. Re-enters CLEAR and discards window history.
- data_in  input  32  signed input sample.
- data_in_valid  input  1  sample strobe. A sample is accepted only when data_in_valid=1 and data_in_ready=1.
- data_in_ready  output  1  high only in RUN state.
- mean_out  output  32  signed windowed mean.
- mean_out_valid  output  1  one-cycle strobe per output sample.
- window_full  output  1  high once M samples have been accepted since the last clear.

Behaviour:
- Reset (reset_n=0, async):
  - state=CLEAR, clear index=0, write index=0, accumulator=0, fill counter=0.
  - All pipeline valid bits are cleared.
  - Outputs: mean_out=0, mean_out_valid=0, data_in_ready=0, window_full=0.
- FSM, CLEAR state:
  - Writes 0 to buffer[clr_idx] every cycle; clr_idx increments 0..M-1.
  - On the cycle that writes M-1, go to RUN.
  - CLEAR lasts exactly M cycles. data_in_ready=0 throughout, so inputs offered are ignored (not queued).
- FSM, RUN state:
  - data_in_ready=1.
  - restart=1 in any state: next state CLEAR, clr_idx=0, accumulator=0, fill counter=0, window_full=0.
  - restart also flushes all pipeline valid bits, so no mean_out_valid is issued for samples already in flight.
  - restart takes priority over a same-cycle accepted sample; that sample is dropped.
- Pipeline. Free-running, one valid bit per stage. Latency from accept to mean_out_valid is exactly 4 clocks.
  - S1: register data_in and the write index. The write index wraps M-1 -> 0. Increment the fill counter, saturating at M.
  - S2: read old = buffer[idx]; write buffer[idx] = new.
  - S3: acc <= acc + new - old.
  - S4: mean_out <= acc >>> LOG2M (arithmetic shift, rounds toward -inf). mean_out_valid <= S3 valid AND warm.
- Warm flag:
  - warm is set on the M-th accepted sample and travels with that sample's valid bit. The first strobed output is therefore the mean of samples 1..M.
  - window_full asserts in the same cycle as the first mean_out_valid and stays high until restart or reset.
- Accumulator width: 32+LOG2M bits, signed, so it cannot overflow. Output is the low 32 bits after the shift, which is always representable.
- Back-to-back accepts, one per clock: supported. Read and write indices of in-flight samples never collide, because M >= 4 exceeds pipeline depth.
- Gaps (data_in_valid=0): pipeline drains normally. mean_out holds its last value; mean_out_valid=0.
- mean_out updates only on cycles where mean_out_valid=1.

Test Plan:
- Reset-then-clear (M=4): release reset, hold data_in_valid=1 -> data_in_ready low for exactly 4 cycles, then high. No samples are accepted during clear.
- Constant input (M=4): 100 accepted every cycle -> first mean_out_valid 4 clocks after the 4th accept, mean_out=100. Every following output is 100. window_full rises with that first strobe.
- Ramp with gaps (M=4): samples 1..8, valid asserted every other cycle -> outputs 2, 3, 4, 5, 6 (floor of 10/4, 14/4, ...). Strobes track the accepts with 4-cycle latency and no spurious strobes.
- Negative and floor rounding (M=4): inputs -1, 0, 0, 0 -> mean_out=-1. Then -8 x4 -> mean_out=-8.
- Extremes (M=32): 32 x 0x7FFFFFFF -> 0x7FFFFFFF; then 32 x 0x80000000 -> 0x80000000. No wrap is allowed.
- Restart mid-stream (M=4): accept 6 samples, pulse restart with a sample in flight -> no strobe for the in-flight samples, window_full=0, a 4-cycle CLEAR, then a full re-warm before the next strobe. Repeat the same check with reset_n asserted mid-stream -> all outputs read 0 immediately (async).

Source files
------------

// File: rtl/moving_average_pipelined.sv
// Streaming boxcar mean over the last M signed 32-bit samples.
// Circular buffer plus running accumulator, 4-stage pipeline, zero-fill clear sequence.
module moving_average_pipelined #(
  parameter int unsigned M     = 32,
  parameter int unsigned LOG2M = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               restart,
  input  logic signed [31:0] data_in,
  input  logic               data_in_valid,
  output logic               data_in_ready,
  output logic signed [31:0] mean_out,
  output logic               mean_out_valid,
  output logic               window_full
);

  localparam int unsigned AccW = 32 + LOG2M;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e             state_q, state_d;
  logic [LOG2M-1:0]   clr_idx_q, clr_idx_d;
  logic [LOG2M-1:0]   wr_idx_q;
  logic [LOG2M:0]     fill_q;
  logic               accept;

  logic signed [31:0] buffer [M];

  logic               s1_valid_q, s1_warm_q;
  logic signed [31:0] s1_data_q;
  logic [LOG2M-1:0]   s1_idx_q;
  logic               s2_valid_q, s2_warm_q;
  logic signed [31:0] s2_new_q, s2_old_q;
  logic               s3_valid_q, s3_warm_q;
  logic signed [AccW-1:0] acc_q;
  logic signed [31:0] mean_q;
  logic               mean_valid_q;
  logic               window_full_q;

  assign data_in_ready  = (state_q == StRun);
  // restart wins over a same-cycle sample
  assign accept         = data_in_valid & data_in_ready & ~restart;
  assign mean_out       = mean_q;
  assign mean_out_valid = mean_valid_q;
  assign window_full    = window_full_q;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      StClear: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LOG2M'(M - 1)) state_d = StRun;
      end
      StRun: ;
      default: state_d = StClear;
    endcase
    if (restart) begin
      state_d   = StClear;
      clr_idx_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Buffer has no reset: the clear sequence zero-fills it after every reset/restart.
  always_ff @(posedge clock) begin
    if (state_q == StClear) begin
      buffer[clr_idx_q] <= '0;
    end else if (s1_valid_q) begin
      buffer[s1_idx_q] <= s1_data_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_idx_q      <= '0;
      fill_q        <= '0;
      s1_valid_q    <= 1'b0;
      s1_warm_q     <= 1'b0;
      s1_data_q     <= '0;
      s1_idx_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_warm_q     <= 1'b0;
      s2_new_q      <= '0;
      s2_old_q      <= '0;
      s3_valid_q    <= 1'b0;
      s3_warm_q     <= 1'b0;
      acc_q         <= '0;
      mean_q        <= '0;
      mean_valid_q  <= 1'b0;
      window_full_q <= 1'b0;
    end else begin
      // S1
      s1_valid_q <= accept;
      if (accept) begin
        s1_data_q <= data_in;
        s1_idx_q  <= wr_idx_q;
        wr_idx_q  <= wr_idx_q + 1'b1;
        // fill saturates at M, so this sample is the M-th or later
        s1_warm_q <= (fill_q >= (LOG2M + 1)'(M - 1));
      end
      if (restart) begin
        fill_q <= '0;
      end else if (accept && (fill_q != (LOG2M + 1)'(M))) begin
        fill_q <= fill_q + 1'b1;
      end

      // S2
      s2_valid_q <= s1_valid_q & ~restart;
      if (s1_valid_q) begin
        s2_new_q  <= s1_data_q;
        s2_old_q  <= buffer[s1_idx_q];
        s2_warm_q <= s1_warm_q;
      end

      // S3
      s3_valid_q <= s2_valid_q & ~restart;
      s3_warm_q  <= s2_warm_q;
      if (restart) begin
        acc_q <= '0;
      end else if (s2_valid_q) begin
        acc_q <= acc_q + {{LOG2M{s2_new_q[31]}}, s2_new_q} - {{LOG2M{s2_old_q[31]}}, s2_old_q};
      end

      // S4
      mean_valid_q <= s3_valid_q & s3_warm_q & ~restart;
      if (s3_valid_q && s3_warm_q && !restart) begin
        mean_q <= 32'(acc_q >>> LOG2M);
      end
      if (restart) begin
        window_full_q <= 1'b0;
      end else if (s3_valid_q && s3_warm_q) begin
        window_full_q <= 1'b1;
      end
    end
  end

endmodule
